// File: rtl/alu_pkg.sv
// Shared opcode encodings, tag width and flag bit positions for the execute-stage ALU.
// Flag indices are only consumed when ALU_FLAGS_EN is defined.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam int unsigned TAG_W  = 5;

    // out_flags layout is {N, Z, C, V}
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned FLAG_V = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: maps {a, b, op} to {result, illegal[, flags]}.
// Optional NZCV flag output is enabled by ALU_FLAGS_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic [3:0]        op,
    output logic [XLEN-1:0]   result,
`ifdef ALU_FLAGS_EN
    output logic [FLAG_W-1:0] flags,
`endif
    output logic              illegal
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);

    logic [XLEN-1:0]    sum;
    logic [XLEN-1:0]    diff;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = b[SHAMT_W-1:0];

`ifdef ALU_FLAGS_EN
    logic [XLEN:0] sum_ext;
    logic [XLEN:0] diff_ext;

    // diff_ext[XLEN] is the carry of a + ~b + 1, i.e. NOT borrow
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
    assign sum      = sum_ext[XLEN-1:0];
    assign diff     = diff_ext[XLEN-1:0];
`else
    assign sum  = a + b;
    assign diff = a - b;
`endif

    always_comb begin
        result  = '0;
        illegal = 1'b0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_ADD:  result = sum;
            ALU_SUB:  result = diff;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
            default:  illegal = 1'b1;
        endcase
    end

`ifdef ALU_FLAGS_EN
    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[XLEN-1];
        flags[FLAG_Z] = (result == '0);
        if (op == ALU_ADD) begin
            flags[FLAG_C] = sum_ext[XLEN];
            flags[FLAG_V] = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
        end else if (op == ALU_SUB) begin
            flags[FLAG_C] = diff_ext[XLEN];
            flags[FLAG_V] = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
        end
    end
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined integer ALU with valid/ready handshake and backpressure.
// Define ALU_FLAGS_EN to add the registered out_flags {N, Z, C, V} port.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    input  logic [3:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
`ifdef ALU_FLAGS_EN
    output logic [FLAG_W-1:0] out_flags,
`endif
    output logic              out_illegal
);

    logic              s1_valid;
    logic [XLEN-1:0]   s1_a;
    logic [XLEN-1:0]   s1_b;
    logic [3:0]        s1_op;
    logic [TAG_W-1:0]  s1_tag;
    logic              s2_valid;
    logic              s1_adv;
    logic              s2_adv;
    logic [XLEN-1:0]   core_result;
    logic              core_illegal;
`ifdef ALU_FLAGS_EN
    logic [FLAG_W-1:0] core_flags;
`endif

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    alu_core #(
        .XLEN (XLEN)
    ) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .op      (s1_op),
        .result  (core_result),
`ifdef ALU_FLAGS_EN
        .flags   (core_flags),
`endif
        .illegal (core_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
            s1_tag   <= '0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_op  <= in_op;
                s1_tag <= in_tag;
            end
        end
    end

    // Payload only loads with a real beat so out_* never sees stale S1 contents
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid    <= 1'b0;
            out_result  <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
`ifdef ALU_FLAGS_EN
            out_flags   <= '0;
`endif
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= core_result;
                out_tag     <= s1_tag;
                out_illegal <= core_illegal;
`ifdef ALU_FLAGS_EN
                out_flags   <= core_flags;
`endif
            end
        end
    end

endmodule
